// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the rv32 in-order core.
// Holds the packet types that travel between pipeline stages and the
// default depth used when proc_top instantiates pipe_elastic buffers.
package rv32_pkg;

  // Default number of entries in each inter-stage elastic buffer.
  localparam int PIPE_DEPTH_DEFAULT = 2;

  // Fetch -> operand-fetch packet, a typical PTYPE for pipe_elastic.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } rv32_if_packet_t;

endpackage

// File: rtl/pipe_ring_ptr.sv
// pipe_ring_ptr: circular-buffer pointer that counts 0..DEPTH-1 and wraps
// from DEPTH-1 back to 0. DEPTH need not be a power of two.
// Ports:
//   clk    in   clock, rising edge
//   resetn in   asynchronous active-low reset (pointer -> 0)
//   clr    in   synchronous clear (pointer -> 0), wins over inc
//   inc    in   advance the pointer by one entry
//   ptr    out  current pointer value
module pipe_ring_ptr #(
  parameter int  DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pipe_elastic.sv
// pipe_elastic: DEPTH-entry elastic buffer between two pipeline stages with
// valid/ready handshakes on both sides, synchronous flush, occupancy output
// and an optional zero-latency fall-through path when empty.
// Ports:
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   din_packet   in   packet from the producer stage
//   din_valid    in   producer has a packet
//   din_ready    out  buffer can accept a packet (registered state only)
//   dout_packet  out  head packet ('0 whenever dout_valid is low)
//   dout_valid   out  head packet is valid
//   dout_ready   in   consumer takes the head packet this cycle
//   flush        in   drop everything buffered and anything offered this cycle
//   count        out  number of occupied entries
module pipe_elastic
  import rv32_pkg::*;
#(
  parameter type PTYPE        = logic [31:0],
  parameter int  DEPTH        = PIPE_DEPTH_DEFAULT,
  parameter bit  FALL_THROUGH = 1'b0,
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  PTYPE             din_packet,
  input  logic             din_valid,
  output logic             din_ready,
  output PTYPE             dout_packet,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  PTYPE             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_reg;

  logic empty;
  logic ft_active;
  logic bypass;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_adv;

  assign empty = (count_reg == '0);

  // Fall-through: an empty buffer presents the incoming packet directly.
  // Gated by resetn so outputs read as idle while reset is held.
  assign ft_active = FALL_THROUGH && resetn && empty && din_valid && !flush;

  // Forwarded packet consumed in the same cycle: it never touches storage.
  assign bypass = ft_active && dout_ready;

  assign din_ready  = (count_reg < CNT_W'(DEPTH));
  assign dout_valid = !flush && (!empty || ft_active);

  assign push = din_valid && din_ready && !flush;
  assign pop  = dout_valid && dout_ready && !flush;

  assign wr_en  = push && !bypass;
  assign rd_adv = pop && !bypass;

  always_comb begin
    dout_packet = '0;
    if (dout_valid) begin
      dout_packet = empty ? din_packet : mem[rd_ptr];
    end
  end

  // Storage is not cleared by flush; dout_packet masks stale entries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= din_packet;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else if (wr_en && !rd_adv) begin
      count_reg <= count_reg + CNT_W'(1);
    end else if (rd_adv && !wr_en) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign count = count_reg;

  pipe_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .inc    (rd_adv),
    .ptr    (rd_ptr)
  );

  pipe_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .inc    (wr_en),
    .ptr    (wr_ptr)
  );

`ifndef SYNTHESIS
  // Producer must hold its packet while stalled.
  a_din_stable: assert property (@(posedge clk) disable iff (!resetn)
    (din_valid && !din_ready && !flush) |=> $stable(din_packet));

  // A stalled head packet may only disappear through flush.
  a_dout_valid_held: assert property (@(posedge clk) disable iff (!resetn)
    (dout_valid && !dout_ready && !flush) |=> (dout_valid || flush));

  a_dout_packet_held: assert property (@(posedge clk) disable iff (!resetn)
    (dout_valid && !dout_ready && !flush) |=> (flush || $stable(dout_packet)));
`endif

endmodule

// File: tb/tb_pipe_elastic.sv
// tb_pipe_elastic: four pipe_elastic instances share one stimulus stream:
//   inst0 DEPTH=2 FT=0, inst1 DEPTH=3 FT=0, inst2 DEPTH=2 FT=1, inst3 DEPTH=4 FT=0.
// A queue-based model checks every instance on every falling edge; directed
// checks with literal values pin the individual scenarios.
module tb_pipe_elastic;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] din_packet;
  logic        din_valid;
  logic        dout_ready;
  logic        flush;
  logic [3:0]  en;

  logic [3:0]  din_ready_o;
  logic [3:0]  dout_valid_o;
  logic [31:0] dout_packet_o [4];
  int          count_o [4];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int D  = (gi == 0) ? 2 : (gi == 1) ? 3 : (gi == 2) ? 2 : 4;
      localparam bit FT = (gi == 2);
      logic [$clog2(D+1)-1:0] cnt;
      logic [31:0]            pkt;

      pipe_elastic #(.PTYPE(logic [31:0]), .DEPTH(D), .FALL_THROUGH(FT)) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .din_packet  (din_packet),
        .din_valid   (din_valid & en[gi]),
        .din_ready   (din_ready_o[gi]),
        .dout_packet (pkt),
        .dout_valid  (dout_valid_o[gi]),
        .dout_ready  (dout_ready),
        .flush       (flush),
        .count       (cnt)
      );

      assign count_o[gi]       = int'(cnt);
      assign dout_packet_o[gi] = pkt;
    end
  endgenerate

  function automatic int dep_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Behavioural model: each buffer is a plain FIFO queue.
  logic [31:0] mq [4][$];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int          n;
      bit          dv, fwd, ev, er;
      logic [31:0] ep;
      if (!resetn) begin
        mq[i].delete();
        chk($sformatf("model[%0d] rst dout_valid", i), 32'(dout_valid_o[i]), 32'd0);
        chk($sformatf("model[%0d] rst dout_packet", i), dout_packet_o[i], 32'd0);
        chk($sformatf("model[%0d] rst din_ready", i), 32'(din_ready_o[i]), 32'd1);
        chk($sformatf("model[%0d] rst count", i), 32'(count_o[i]), 32'd0);
      end else begin
        n   = mq[i].size();
        dv  = din_valid && en[i];
        fwd = (i == 2) && (n == 0) && dv && !flush;
        ev  = !flush && (n > 0 || fwd);
        ep  = !ev ? 32'd0 : (n > 0) ? mq[i][0] : din_packet;
        er  = (n < dep_of(i));
        chk($sformatf("model[%0d] dout_valid", i), 32'(dout_valid_o[i]), 32'(ev));
        chk($sformatf("model[%0d] dout_packet", i), dout_packet_o[i], ep);
        chk($sformatf("model[%0d] din_ready", i), 32'(din_ready_o[i]), 32'(er));
        chk($sformatf("model[%0d] count", i), 32'(count_o[i]), 32'(n));
        if (flush) begin
          mq[i].delete();
        end else begin
          if (ev && dout_ready) $display("inst%0d pop 0x%0h", i, ep);
          if (ev && dout_ready && n > 0) void'(mq[i].pop_front());
          if (dv && er && !(fwd && dout_ready)) begin
            mq[i].push_back(din_packet);
            $display("inst%0d push 0x%0h", i, din_packet);
          end
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] p, input bit rdy, input bit fl);
    din_valid  = v;
    din_packet = p;
    dout_ready = rdy;
    flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_inst(input string nm, input int i, input bit v,
                          input logic [31:0] p, input bit r, input int c);
    chk({nm, " dout_valid"}, 32'(dout_valid_o[i]), 32'(v));
    chk({nm, " dout_packet"}, dout_packet_o[i], p);
    chk({nm, " din_ready"}, 32'(din_ready_o[i]), 32'(r));
    chk({nm, " count"}, 32'(count_o[i]), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    en     = 4'b1111;
    drive(0, 32'h0, 0, 0);
    tick();
    tick();
    resetn = 1'b1;

    // 1: idle after reset
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_inst($sformatf("t1 idle%0d", k), 0, 0, 32'h0, 1, 0);
      tick();
    end

    // 2: fill and backpressure (inst0, DEPTH=2)
    drive(1, 32'hA, 0, 0);
    @(negedge clk); chk_inst("t2 c1", 0, 0, 32'h0, 1, 0);
    chk("t2 c1 ft dout_packet", dout_packet_o[2], 32'hA);
    tick();
    drive(1, 32'hB, 0, 0);
    @(negedge clk); chk_inst("t2 c2", 0, 1, 32'hA, 1, 1);
    tick();
    drive(0, 32'h0, 0, 0);
    @(negedge clk); chk_inst("t2 c3", 0, 1, 32'hA, 0, 2);
    tick();
    @(negedge clk); chk_inst("t2 c4", 0, 1, 32'hA, 0, 2);
    tick();
    drive(0, 32'h0, 1, 0);
    @(negedge clk); chk_inst("t2 pop1", 0, 1, 32'hA, 0, 2);
    tick();
    @(negedge clk); chk_inst("t2 pop2", 0, 1, 32'hB, 1, 1);
    tick();
    @(negedge clk); chk_inst("t2 empty", 0, 0, 32'h0, 1, 0);
    tick();

    // 3: streaming with wrap (inst1, DEPTH=3)
    for (int k = 1; k <= 10; k++) begin
      drive(1, 32'(k), 1, 0);
      @(negedge clk);
      if (k == 1) chk_inst("t3 first", 1, 0, 32'h0, 1, 0);
      else        chk_inst($sformatf("t3 k%0d", k), 1, 1, 32'(k - 1), 1, 1);
      tick();
    end
    drive(0, 32'h0, 1, 0);
    @(negedge clk); chk_inst("t3 last", 1, 1, 32'd10, 1, 1);
    tick();
    @(negedge clk); chk_inst("t3 drained", 1, 0, 32'h0, 1, 0);
    tick();

    // 4: fall-through (inst2, DEPTH=2 FT=1)
    drive(1, 32'h55, 1, 0);
    @(negedge clk); chk_inst("t4 bypass", 2, 1, 32'h55, 1, 0);
    tick();
    drive(0, 32'h0, 1, 0);
    @(negedge clk); chk_inst("t4 after bypass", 2, 0, 32'h0, 1, 0);
    tick();
    drive(1, 32'h55, 0, 0);
    @(negedge clk); chk_inst("t4 ft stall", 2, 1, 32'h55, 1, 0);
    tick();
    drive(0, 32'h0, 0, 0);
    @(negedge clk); chk_inst("t4 held", 2, 1, 32'h55, 1, 1);
    tick();
    drive(0, 32'h0, 1, 0);
    @(negedge clk);
    tick();
    drive(0, 32'h0, 0, 0);

    // 5: flush with simultaneous push/pop (inst3, DEPTH=4)
    en = 4'b1000;
    drive(1, 32'h1, 0, 0); tick();
    drive(1, 32'h2, 0, 0); tick();
    drive(1, 32'h3, 0, 0); tick();
    drive(1, 32'h4, 1, 1);
    @(negedge clk); chk_inst("t5 flush cycle", 3, 0, 32'h0, 1, 3);
    tick();
    drive(0, 32'h0, 0, 0);
    @(negedge clk); chk_inst("t5 after flush", 3, 0, 32'h0, 1, 0);
    tick();
    drive(1, 32'h5, 0, 0);
    @(negedge clk); chk_inst("t5 push5", 3, 0, 32'h0, 1, 0);
    tick();
    drive(0, 32'h0, 0, 0);
    @(negedge clk); chk_inst("t5 head5", 3, 1, 32'h5, 1, 1);
    tick();
    drive(0, 32'h0, 1, 0);
    @(negedge clk);
    tick();
    drive(0, 32'h0, 0, 0);
    en = 4'b1111;

    // 6: asynchronous reset while full (inst0)
    drive(1, 32'h7, 0, 0); tick();
    drive(1, 32'h8, 0, 0); tick();
    drive(0, 32'h0, 0, 0);
    @(negedge clk); chk_inst("t6 full", 0, 1, 32'h7, 0, 2);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk_inst("t6 async rst", 0, 0, 32'h0, 1, 0);
    chk_inst("t6 async rst ft", 2, 0, 32'h0, 1, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(1, 32'h9, 0, 0);
    @(negedge clk); chk_inst("t6 push9", 0, 0, 32'h0, 1, 0);
    tick();
    drive(0, 32'h0, 0, 0);
    @(negedge clk); chk_inst("t6 head9", 0, 1, 32'h9, 1, 1);
    tick();
    drive(0, 32'h0, 1, 0);
    @(negedge clk);
    tick();
    drive(0, 32'h0, 0, 0);
    @(negedge clk); chk_inst("t6 drained", 0, 0, 32'h0, 1, 0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_elastic.md
Name: pipe_elastic

Overview:
Parametrised successor to the stall-based `pipe` register. It is a DEPTH-entry elastic pipeline buffer with valid/ready handshakes on both sides, a synchronous flush, an occupancy output and an optional zero-latency fall-through mode. It sits between any two pipeline stages of the in-order core, for example IF->OF or EX->MEM. It lets stages decouple without a global stall net, and it lets branch redirection kill in-flight packets.

Parameters:
- PTYPE, logic [31:0], type of the carried packet (e.g. rv32_if_packet_t).
- DEPTH, 2, number of storage entries; must be >= 1; need not be a power of two.
- FALL_THROUGH, 0, when 1 an empty buffer forwards din to dout combinationally in the same cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- din_packet  in  PTYPE  packet from the producer stage.
- din_valid  in  1  producer has a packet.
- din_ready  out  1  buffer can accept a packet this cycle.
- dout_packet  out  PTYPE  head packet to the consumer stage.
- dout_valid  out  1  head packet is valid.
- dout_ready  in  1  consumer accepts the head packet this cycle.
- flush  in  1  discard all buffered packets and any packet pushed this cycle.
- count  out  $clog2(DEPTH+1)  current number of occupied entries.

Behaviour:
- Storage is a circular buffer with rd_ptr, wr_ptr (each 0..DEPTH-1) and count (0..DEPTH).
- A pointer increments with wrap: it goes from DEPTH-1 to 0.
- Reset, asserted asynchronously at any time, including mid-transfer:
  - rd_ptr = wr_ptr = 0, count = 0;
  - all storage entries = '0;
  - dout_valid = 0, dout_packet = '0, din_ready = 1.
- push = din_valid & din_ready & ~flush. pop = dout_valid & dout_ready & ~flush.
- din_ready = (count < DEPTH). It is a function of registered state only. There is no combinational path from dout_ready to din_ready.
- FALL_THROUGH = 0:
  - dout_valid = (count != 0); dout_packet = mem[rd_ptr] when valid, otherwise '0.
  - Latency from a push to visibility on dout is 1 cycle.
- FALL_THROUGH = 1, when count == 0 and din_valid = 1 and flush = 0:
  - dout_valid = 1 and dout_packet = din_packet in the same cycle.
  - If dout_ready = 1, the packet is consumed and not written, so count stays 0.
  - If dout_ready = 0, the packet is written and count becomes 1.
  - Latency 0.
- Counter update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
- Full (count == DEPTH):
  - din_ready = 0, so no push happens even if a pop occurs that cycle.
  - din_ready rises the cycle after the pop.
- Empty (count == 0): dout_valid = 0, except in the fall-through case above. dout_packet = '0.
- Flush (synchronous, highest priority):
  - In the flush cycle: dout_valid is forced 0, no push and no pop occur, and din_ready keeps its registered value.
  - Next cycle: count = 0 and rd_ptr = wr_ptr = 0.
  - Storage contents are not cleared, but are unobservable because dout_packet = '0 while invalid.
- No overflow or underflow is possible by construction.
  - An SVA assertion flags din_valid & ~din_ready with a changing din_packet as a protocol violation by the producer. This is a non-synthesised check.
  - A second assertion flags a dout_valid drop without pop or flush.
- Once dout_valid = 1, dout_packet holds stable until pop or flush. The same stability rule applies to din from the producer side.

Decomposition:
- No new package typedefs; PTYPE comes from rv32_pkg at instantiation.
- Add to rv32_pkg: localparam PIPE_DEPTH_DEFAULT = 2, used by proc_top instantiations.
- One natural sub-module: pipe_ring_ptr.
  - Parameter DEPTH; inputs clk, resetn, clr, inc; output ptr.
  - Implements the wrap-at-DEPTH pointer.
  - Instantiated twice, for rd_ptr and wr_ptr.

Test Plan:
1. Reset then idle, DEPTH=2, FT=0: din_valid=0 -> dout_valid=0, din_ready=1, count=0, dout_packet='0 for 10 cycles.
2. Fill and backpressure, DEPTH=2, FT=0:
   - Stimulus: push 0xA, then 0xB with dout_ready=0.
   - count goes 1, then 2; din_ready=0 in cycle 3; dout_packet=0xA held.
   - Raise dout_ready: dout gives 0xA, then 0xB; din_ready returns to 1 one cycle after the first pop.
3. Streaming with wrap, DEPTH=3, FT=0:
   - Stimulus: continuous push of 1..10 with dout_ready=1.
   - Output is 1..10 in order, one per cycle after 1-cycle latency.
   - count steady at 1; pointers wrap from 2 to 0 three times.
4. Fall-through, DEPTH=2, FT=1:
   - Empty buffer, din 0x55 valid, dout_ready=1: dout_packet=0x55 with dout_valid=1 in the same cycle; count stays 0.
   - Repeat with dout_ready=0: count becomes 1 and 0x55 is held on dout.
5. Flush with simultaneous push/pop, DEPTH=4, FT=0:
   - Stimulus: buffer holds 0x1,0x2,0x3; assert flush together with din_valid=1 (0x4) and dout_ready=1.
   - Next cycle: count=0, dout_valid=0; 0x4 never appears.
   - A subsequent push of 0x5 emerges first.
6. Async reset mid-operation, DEPTH=2:
   - Stimulus: buffer full; drop resetn between clock edges.
   - dout_valid=0, count=0 and din_ready=1 immediately, without waiting for a clock edge.
   - After release, the first push of 0x9 appears after 1 cycle.
